// File: rtl/nios_system_sysid_arb_pkg.sv
// nios_system_sysid_arb_pkg: state encoding, sysid word addresses and index-width helper for the sysid arbiter
package nios_system_sysid_arb_pkg;
    typedef enum logic [2:0] {IDLE, RESP, CHK_ID, CHK_TS, CHK_END} state_t;
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    function automatic int clog2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/nios_system_sysid_rr_pick.sv
// nios_system_sysid_rr_pick: combinational round-robin picker; ports req (request vector), ptr (last winner), winner (first requester after ptr, wrapping), any_req
module nios_system_sysid_rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);
    logic [W-1:0] idx;
    // Scan from farthest to nearest so the requester closest after ptr is the last write and wins.
    always_comb begin
        idx = '0;
        winner = ptr;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) winner = idx;
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/nios_system_sysid_arbiter.sv
// nios_system_sysid_arbiter: round-robin sharing of the sysid slave between NUM_MASTERS read masters; optional power-up ID/timestamp self-check under SYSID_CHECK_EN
// Ports: clock, reset_n (sync active-low); m_read/m_address/m_waitrequest/m_readdata/m_readdatavalid per master;
// s_address/s_readdata to the sysid slave; check_done/id_mismatch self-check status (tied 1/0 without SYSID_CHECK_EN).
module nios_system_sysid_arbiter
    import nios_system_sysid_arb_pkg::*;
#(
    parameter int                NUM_MASTERS = 2,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] EXPECTED_ID = '0,
    parameter logic [DATA_W-1:0] EXPECTED_TS = DATA_W'(32'h63D74B10)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_address,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [NUM_MASTERS*DATA_W-1:0] m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic                          s_address,
    input  logic [DATA_W-1:0]             s_readdata,
    output logic                          check_done,
    output logic                          id_mismatch
);
    localparam int GW = clog2(NUM_MASTERS);
`ifdef SYSID_CHECK_EN
    localparam state_t START = CHK_ID;
`else
    localparam state_t START = IDLE;
`endif
    state_t state, state_nxt;
    logic [GW-1:0] ptr, grant, winner;
    logic any_req;

    nios_system_sysid_rr_pick #(.N(NUM_MASTERS), .W(GW)) u_pick (
        .req    (m_read),
        .ptr    (ptr),
        .winner (winner),
        .any_req(any_req)
    );

    always_comb begin
        state_nxt = state;
        m_waitrequest = '1;
        case (state)
            IDLE: begin
                state_nxt = any_req ? RESP : IDLE;
                if (any_req && reset_n) m_waitrequest[winner] = 1'b0;
            end
            RESP:    state_nxt = IDLE;
            CHK_ID:  state_nxt = CHK_TS;
            CHK_TS:  state_nxt = CHK_END;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= START;
            ptr <= GW'(NUM_MASTERS - 1);
            grant <= '0;
            s_address <= SYSID_ADDR_ID;
            m_readdata <= '0;
            m_readdatavalid <= '0;
        end else begin
            state <= state_nxt;
            m_readdatavalid <= '0;
            if (state == CHK_ID) s_address <= SYSID_ADDR_TS;
            if (state == IDLE && any_req) begin
                s_address <= m_address[winner];
                grant <= winner;
                ptr <= winner;
            end
            if (state == RESP) begin
                m_readdata[int'(grant)*DATA_W +: DATA_W] <= s_readdata;
                m_readdatavalid[grant] <= 1'b1;
            end
        end
    end

`ifdef SYSID_CHECK_EN
    // Each word is compared while its address is presented; the verdict is published on entry to IDLE.
    logic id_bad, ts_bad;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            id_bad <= 1'b0;
            ts_bad <= 1'b0;
            check_done <= 1'b0;
            id_mismatch <= 1'b0;
        end else begin
            if (state == CHK_ID) id_bad <= s_readdata != EXPECTED_ID;
            if (state == CHK_TS) ts_bad <= s_readdata != EXPECTED_TS;
            if (state == CHK_END) begin
                check_done <= 1'b1;
                id_mismatch <= id_bad | ts_bad;
            end
        end
    end
`else
    assign check_done = 1'b1;
    assign id_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_nios_system_sysid_arbiter.sv
// tb_nios_system_sysid_arbiter: scoreboard bench for the sysid arbiter with 4 masters, plus a second instance with a wrong expected timestamp
module tb_nios_system_sysid_arbiter;
    localparam int N = 4;
    localparam int DW = 32;
    localparam logic [31:0] TS = 32'h63D74B10;
`ifdef SYSID_CHECK_EN
    localparam int CHK = 3;
`else
    localparam int CHK = 0;
`endif

    typedef struct {int m; logic [31:0] d;} rsp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] m_read = '0;
    logic [N-1:0] m_address = '0;
    logic [N-1:0] wr_a, dv_a, wr_b, dv_b;
    logic [N*DW-1:0] rd_a, rd_b;
    logic sa_a, sa_b, done_a, done_b, mm_a, mm_b;
    logic [DW-1:0] sd_a, sd_b;

    assign sd_a = sa_a ? TS : 32'h0;
    assign sd_b = sa_b ? TS : 32'h0;

    always #5 clock = ~clock;

    nios_system_sysid_arbiter #(.NUM_MASTERS(N), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n), .m_read(m_read), .m_address(m_address),
        .m_waitrequest(wr_a), .m_readdata(rd_a), .m_readdatavalid(dv_a),
        .s_address(sa_a), .s_readdata(sd_a), .check_done(done_a), .id_mismatch(mm_a)
    );

    nios_system_sysid_arbiter #(.NUM_MASTERS(N), .DATA_W(DW), .EXPECTED_TS(32'h1)) dut_bad_ts (
        .clock(clock), .reset_n(reset_n), .m_read(m_read), .m_address(m_address),
        .m_waitrequest(wr_b), .m_readdata(rd_b), .m_readdatavalid(dv_b),
        .s_address(sa_b), .s_readdata(sd_b), .check_done(done_b), .id_mismatch(mm_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    rsp_t sb[$];
    rsp_t pend;
    int mptr, mchk, last_w;
    logic m_resp;
    logic [N*DW-1:0] exp_rd;
    int glog[$];

    task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: predict and compare outputs mid-cycle, then advance the reference model at the edge.
    task automatic step();
        int w;
        logic [N-1:0] exp_wait, exp_v;
        rsp_t r;
        @(negedge clock);
        w = -1;
        exp_wait = '1;
        exp_v = '0;
        if (reset_n && mchk == 0 && !m_resp)
            for (int k = 1; k <= N; k++)
                if (w < 0 && m_read[(mptr + k) % N]) w = (mptr + k) % N;
        if (w >= 0) exp_wait[w] = 1'b0;
        check("waitrequest", wr_a, exp_wait);
        for (int i = 0; i < N; i++) if (!wr_a[i]) glog.push_back(i);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            exp_v[r.m] = 1'b1;
            exp_rd[r.m*DW +: DW] = r.d;
        end
        check("readdatavalid", dv_a, exp_v);
        check("readdata", rd_a, exp_rd);
        check("check_done", done_a, mchk == 0);
        check("id_mismatch", mm_a, 0);
        check("check_done_bad_ts", done_b, mchk == 0);
        check("id_mismatch_bad_ts", mm_b, (CHK > 0) && (mchk == 0));
        last_w = w;
        @(posedge clock);
        if (!reset_n) begin
            mptr = N - 1;
            m_resp = 1'b0;
            sb.delete();
            exp_rd = '0;
            mchk = CHK;
        end else if (mchk > 0) mchk--;
        else if (m_resp) begin
            m_resp = 1'b0;
            sb.push_back(pend);
        end else if (w >= 0) begin
            mptr = w;
            m_resp = 1'b1;
            pend = '{m: w, d: m_address[w] ? TS : 32'h0};
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        for (int i = 0; i < exp.size(); i++)
            check(tag, (glog.size() > i) ? glog[i] : 99, exp[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        repeat (2) @(posedge clock);
        #1;
        mptr = N - 1;
        m_resp = 1'b0;
        mchk = CHK;
        exp_rd = '0;
        run(2);
        reset_n = 1'b1;
        // single read of the timestamp word by M0, also held off through any power-up check
        m_read = 4'b0001;
        m_address = 4'b0001;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            step();
            acc = last_w == 0;
        end
        check("t1_accept", acc, 1);
        m_read = '0;
        run(4);
        // two masters contending continuously
        m_read = 4'b0011;
        m_address = 4'b0010;
        glog.delete();
        run(8);
        check_order("t2_order", '{1, 0, 1, 0});
        // all four masters contending
        m_read = 4'b1111;
        m_address = 4'b1010;
        glog.delete();
        run(10);
        check_order("t3_order", '{1, 2, 3, 0, 1});
        // reset while a response is pending
        m_read = 4'b0110;
        for (int i = 0; i < 6 && !m_resp; i++) step();
        check("t4_in_resp", m_resp, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        m_read = 4'b0011;
        last_w = -1;
        for (int i = 0; i < 10 && last_w < 0; i++) step();
        check("t4_first_grant", last_w, 0);
        m_read = '0;
        run(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
